mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester (F stage) and the data-access requester (M stage) of the 5-stage pipeline. It sequences one memory transaction at a time with a req/ack handshake and returns read data to the owner. It generates per-requester stall outputs, which the hazard unit ORs into StallF/StallD/FlushE. It discards fetches that are killed by a taken branch.

Parameters:
XLEN, 32, data width of memory and requesters
ADDR_W, 32, address width
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_done or if_kill
if_addr  in  ADDR_W  fetch address (PCF)
if_kill  in  1  squash pending/in-flight fetch (PCSrcE)
if_done  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  XLEN  fetched instruction
d_req  in  1  data request; held until d_done
d_we  in  1  1=store, 0=load
d_be  in  XLEN/8  byte enables for stores
d_addr  in  ADDR_W  data address (ALUResultM)
d_wdata  in  XLEN  store data
d_done  out  1  one-cycle pulse: access complete, d_rdata valid for loads
d_rdata  out  XLEN  load data
stall_if  out  1  if_req & ~if_done & ~if_kill
stall_mem  out  1  d_req & ~d_done
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_be  out  XLEN/8  byte enables (all ones for fetch/load)
mem_addr  out  ADDR_W  address
mem_wdata  out  XLEN  write data
mem_ack  in  1  one-cycle completion pulse from memory
mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset values (async, on rst_n=0): state=IDLE; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; if_done=0; d_done=0; if_rdata=0; d_rdata=0; kill flag=0; streak=0.
- State machine: IDLE, FETCH, DATA.
- IDLE, grant decision each cycle:
  - d_req and (streak<MAX_DATA_STREAK or ~if_req) → DATA.
  - else if_req & ~if_kill → FETCH.
  - On a grant, address/we/be/wdata are latched into the mem_* registers; mem_req=1 from the next cycle.
- FETCH/DATA: mem_req and all mem_* outputs held stable until the cycle mem_ack=1. On that edge: mem_req=0, mem_rdata captured into the owner's rdata register, owner's done pulse asserted for the following cycle, state→IDLE.
- Back-to-back: the IDLE cycle that carries a done pulse also evaluates grants, so a new grant is made in that cycle. The requester deasserts req that cycle or presents the next request.
- Latency: request seen in IDLE at cycle 0; mem_req high at cycle 1; ack at cycle k≥1 gives done at k+1. Minimum 2 cycles.
- Streak counter:
  - Increments on each DATA grant made while if_req=1.
  - Clears on any FETCH grant, or when if_req=0 at a DATA grant.
  - Saturates at MAX_DATA_STREAK.
  - When saturated and both requests are pending, FETCH wins.
- Kill:
  - if_kill during FETCH sets the kill flag; the transaction still completes on the memory side.
  - On the ack, if_done is suppressed and if_rdata is not updated; the flag clears.
  - if_kill in IDLE blocks a fetch grant that cycle.
  - if_kill coincident with the if_done cycle forces if_done=0.
- Stores: d_done pulses after ack; d_rdata holds its previous value.
- mem_ack in IDLE (including a stale ack after a mid-transaction reset) is ignored.
- Reset mid-transaction: everything returns to reset values immediately; requesters re-issue.
- Width rules: XLEN/8 byte-enable bits. Fetch and load drive mem_be all-ones. Addresses pass through unmodified; no alignment checking.

Test Plan:
1. Load, memory ack on cycle 3: d_req=1, d_we=0, d_addr=0x100, mem_rdata=0xDEADBEEF → mem_req high cycles 1–3 with addr 0x100; d_done=1 cycle 4 with d_rdata=0xDEADBEEF; stall_mem=1 cycles 0–3.
2. Simultaneous requests: if_req (addr 0x0) and d_req (addr 0x200) both set in cycle 0, ack latency 1 → data served first, then fetch. d_done at cycle 2, fetch granted at cycle 2, if_done at cycle 4.
3. Starvation with MAX_DATA_STREAK=4: if_req held, d_req held continuously → exactly 4 data transactions, then 1 fetch. The streak then resets and the pattern repeats.
4. Kill: fetch 0x40 in flight, if_kill pulsed before ack → no if_done; mem transaction still completes. The next fetch of 0x80 is then served normally with if_done and correct data.
5. Store: d_we=1, d_be=4'b0011, d_wdata=0x12345678 → mem_we=1, mem_be=0011 held until ack; d_done pulses once; d_rdata unchanged.
6. Reset mid-DATA: rst_n low while mem_req=1 → mem_req=0 immediately. A stale mem_ack after release produces no done pulse; state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between the fetch (F) and data (M) requesters
// One transaction at a time; data has priority until it has won MAX_DATA_STREAK grants over a waiting fetch.
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int ADDR_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_done,
  output logic [XLEN-1:0]     if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [XLEN/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  output logic                d_done,
  output logic [XLEN-1:0]     d_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                killFlag;
  logic                ifDoneQ;
  logic                streakSat;
  logic                grantData;
  logic                grantFetch;

  assign streakSat  = (streak == STREAK_W'(MAX_DATA_STREAK));
  assign grantData  = d_req && (!streakSat || !if_req);
  assign grantFetch = !grantData && if_req && !if_kill;

  // A branch squash arriving with the done pulse still has to hide that instruction.
  assign if_done   = ifDoneQ && !if_kill;
  assign stall_if  = if_req && !if_done && !if_kill;
  assign stall_mem = d_req && !d_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      killFlag  <= 1'b0;
      ifDoneQ   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ifDoneQ <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grantData) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : '1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req)
              streak <= '0;
            else if (!streakSat)
              streak <= streak + 1'b1;
          end else if (grantFetch) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= '1;
            mem_addr <= if_addr;
            streak   <= '0;
          end
        end
        FETCH: begin
          if (if_kill)
            killFlag <= 1'b1;
          // A squashed fetch still runs to completion on the memory side.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            killFlag <= 1'b0;
            if (!killFlag && !if_kill) begin
              if_rdata <= mem_rdata;
              ifDoneQ  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            d_done  <= 1'b1;
            if (!mem_we)
              d_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int MAXS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_kill, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              d_req, d_we, d_done;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata, d_rdata;
  logic              stall_if, stall_mem;
  logic              mem_req, mem_we, mem_ack;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic act, input logic want);
    totalCnt++;
    if (act === want) passCnt++;
    else $display("FAIL %s: got %b expected %b", name, act, want);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    totalCnt++;
    if (act === want) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    if_req = 0; if_addr = '0; if_kill = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic doReset();
    rst_n = 0;
    idleInputs();
    #3;
    rst_n = 1;
    tick();
  endtask

  typedef struct {
    logic        isFetch;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  expBe;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  task automatic runVec(input vec_t v, input int n);
    if (v.isFetch) begin
      if_req = 1; if_addr = v.addr;
    end else begin
      d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end
    #1;
    chk($sformatf("v%0d stall c0", n), v.isFetch ? stall_if : stall_mem, 1'b1);
    chk($sformatf("v%0d mem_req c0", n), mem_req, 1'b0);
    for (int c = 1; c <= v.lat; c++) begin
      tick();
      mem_ack = (c == v.lat);
      mem_rdata = (c == v.lat) ? v.rdata : 32'h0BAD0BAD;
      #1;
      chk($sformatf("v%0d mem_req c%0d", n, c), mem_req, 1'b1);
      chk32($sformatf("v%0d mem_addr c%0d", n, c), mem_addr, v.addr);
      chk($sformatf("v%0d mem_we c%0d", n, c), mem_we, v.we);
      chk32($sformatf("v%0d mem_be c%0d", n, c), 32'(mem_be), 32'(v.expBe));
      if (v.we) chk32($sformatf("v%0d mem_wdata c%0d", n, c), mem_wdata, v.wdata);
      chk($sformatf("v%0d stall c%0d", n, c), v.isFetch ? stall_if : stall_mem, 1'b1);
    end
    tick();
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk($sformatf("v%0d done", n), v.isFetch ? if_done : d_done, 1'b1);
    chk32($sformatf("v%0d rdata", n), v.isFetch ? if_rdata : d_rdata, v.expRdata);
    chk($sformatf("v%0d mem_req after ack", n), mem_req, 1'b0);
    chk($sformatf("v%0d stall at done", n), v.isFetch ? stall_if : stall_mem, 1'b0);
    if_req = 0; d_req = 0; d_we = 0;
    tick();
    chk($sformatf("v%0d done single pulse", n), v.isFetch ? if_done : d_done, 1'b0);
  endtask

  // Random-phase environment and requester models
  logic [31:0] envMem[64];
  logic [31:0] refMem[64];
  logic        fPend, dPend, dWe;
  logic [31:0] fAddr, dAddr, dWdata, lastLoad, expIfRdata;
  logic [3:0]  dBe;
  logic        inTxn, txnFetch, txnKilled, ackValid, ackFetch, ackKilled;
  logic        prevIfReq, prevKill, prevDReq, expD, expI;
  logic [31:0] sAddr, sWdata;
  logic [3:0]  sBe;
  logic        sWe;
  int          latLeft, run, nTx;
  logic        kinds[10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'b0101, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 4'b0011, 32'h104, 32'h12345678, 32'h55555555, 2, 4'b0011, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 4'b0000, 32'h40, 32'h0, 32'h00A00093, 1, 4'hF, 32'h00A00093};
    vecs[3] = '{1'b0, 1'b0, 4'b0000, 32'h108, 32'h0, 32'hCAFEF00D, 1, 4'hF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 4'b1000, 32'h10C, 32'hA1B2C3D4, 32'h66666666, 4, 4'b1000, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 4'b0000, 32'h44, 32'h0, 32'h00408113, 2, 4'hF, 32'h00408113};

    // Reset state
    rst_n = 0;
    idleInputs();
    #12;
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk32("rst mem_be", 32'(mem_be), 32'h0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_done", if_done, 1'b0);
    chk("rst d_done", d_done, 1'b0);
    chk32("rst if_rdata", if_rdata, 32'h0);
    chk32("rst d_rdata", d_rdata, 32'h0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 6; i++) runVec(vecs[i], i);

    // Simultaneous requests: data first, fetch granted in the d_done cycle
    if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h200;
    #1;
    chk("sim stall_if c0", stall_if, 1'b1);
    chk("sim stall_mem c0", stall_mem, 1'b1);
    tick();
    chk("sim mem_req c1", mem_req, 1'b1);
    chk32("sim data first", mem_addr, 32'h200);
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 0;
    chk("sim d_done c2", d_done, 1'b1);
    chk32("sim d_rdata c2", d_rdata, 32'hA5A5A5A5);
    chk("sim if_done c2", if_done, 1'b0);
    d_req = 0;
    tick();
    chk("sim mem_req c3", mem_req, 1'b1);
    chk32("sim fetch second", mem_addr, 32'h0);
    mem_ack = 1; mem_rdata = 32'h00000013;
    tick();
    mem_ack = 0;
    chk("sim if_done c4", if_done, 1'b1);
    chk32("sim if_rdata c4", if_rdata, 32'h00000013);
    if_req = 0;
    tick();
    chk("sim if_done c5", if_done, 1'b0);

    // Starvation: both held, single-cycle acks
    if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h200;
    nTx = 0;
    for (int cyc = 0; cyc < 80 && nTx < 10; cyc++) begin
      tick();
      mem_ack = mem_req;
      mem_rdata = (mem_addr == 32'h200) ? 32'hD00D0000 : 32'h0000F00D;
      if (mem_req) begin
        kinds[nTx] = (mem_addr == 32'h200);
        nTx++;
      end
    end
    chk32("starve txn count", 32'(nTx), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve txn %0d is data", i), kinds[i], (i % 5) != 4);
    tick();
    mem_ack = 0; if_req = 0; d_req = 0;
    tick();
    expIfRdata = 32'h0000F00D;

    // Kill: in IDLE blocks grant; in flight suppresses done; coincident with done hides it
    if_req = 1; if_kill = 1; if_addr = 32'h40;
    tick();
    chk("kill idle blocks grant", mem_req, 1'b0);
    if_kill = 0;
    tick();
    chk("kill fetch granted", mem_req, 1'b1);
    chk32("kill fetch addr", mem_addr, 32'h40);
    if_kill = 1; if_req = 0;
    tick();
    if_kill = 0;
    chk("kill still in flight", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 0;
    chk("kill no if_done", if_done, 1'b0);
    chk32("kill if_rdata kept", if_rdata, expIfRdata);
    chk("kill mem_req dropped", mem_req, 1'b0);
    if_req = 1; if_addr = 32'h80;
    tick();
    chk("kill next fetch req", mem_req, 1'b1);
    chk32("kill next fetch addr", mem_addr, 32'h80);
    mem_ack = 1; mem_rdata = 32'h22222222;
    tick();
    mem_ack = 0;
    chk("kill next if_done", if_done, 1'b1);
    chk32("kill next if_rdata", if_rdata, 32'h22222222);
    if_addr = 32'h84;
    tick();
    chk32("kill b2b fetch addr", mem_addr, 32'h84);
    mem_ack = 1; mem_rdata = 32'h33333333;
    tick();
    mem_ack = 0; if_kill = 1; if_req = 0;
    #1;
    chk("kill coincident done", if_done, 1'b0);
    tick();
    if_kill = 0;
    chk("kill coincident after", if_done, 1'b0);

    // Reset in the middle of a data transaction, then a stale ack
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick();
    chk("rstmid mem_req before", mem_req, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("rstmid mem_req async", mem_req, 1'b0);
    d_req = 0;
    tick();
    rst_n = 1;
    tick();
    mem_ack = 1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 0;
    chk("rstmid stale ack d_done", d_done, 1'b0);
    chk("rstmid stale ack mem_req", mem_req, 1'b0);
    tick();
    chk("rstmid idle d_done", d_done, 1'b0);
    chk("rstmid idle mem_req", mem_req, 1'b0);
    chk32("rstmid d_rdata", d_rdata, 32'h0);

    // Randomized traffic against a memory/requester model
    for (int i = 0; i < 64; i++) begin
      envMem[i] = $urandom;
      refMem[i] = envMem[i];
    end
    doReset();
    fPend = 0; dPend = 0; dWe = 0; fAddr = '0; dAddr = 32'h80; dWdata = '0; dBe = '0;
    lastLoad = '0; inTxn = 0; txnFetch = 0; txnKilled = 0; ackValid = 0; ackFetch = 0;
    ackKilled = 0; prevIfReq = 0; prevKill = 0; prevDReq = 0; run = 0; latLeft = 0;
    sAddr = '0; sWdata = '0; sBe = '0; sWe = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if_kill = fPend && ($urandom_range(0, 15) == 0);
      #1;
      expD = ackValid && !ackFetch;
      expI = ackValid && ackFetch && !ackKilled && !if_kill;
      chk("rnd d_done", d_done, expD);
      chk("rnd if_done", if_done, expI);
      if (expI) chk32("rnd if_rdata", if_rdata, refMem[fAddr[7:2]]);
      if (expD && dPend) begin
        if (dWe) begin
          chk32("rnd store keeps d_rdata", d_rdata, lastLoad);
          for (int b = 0; b < 4; b++)
            if (dBe[b]) refMem[dAddr[7:2]][8*b +: 8] = dWdata[8*b +: 8];
        end else begin
          chk32("rnd load d_rdata", d_rdata, refMem[dAddr[7:2]]);
          lastLoad = refMem[dAddr[7:2]];
        end
        dPend = 0;
      end
      if (if_kill || expI) fPend = 0;
      if (!fPend && !if_kill && $urandom_range(0, 2) != 0) begin
        fPend = 1;
        fAddr = 32'($urandom_range(0, 31)) << 2;
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend = 1;
        dWe = 1'($urandom_range(0, 1));
        dBe = 4'($urandom_range(1, 15));
        dAddr = 32'h80 + (32'($urandom_range(0, 31)) << 2);
        dWdata = $urandom;
      end
      if_req = fPend; if_addr = fAddr;
      d_req = dPend; d_we = dWe; d_be = dBe; d_addr = dAddr; d_wdata = dWdata;
      ackValid = 0;
      mem_ack = 0; mem_rdata = $urandom;
      if (!mem_req && inTxn) begin
        chk("rnd mem_req held until ack", mem_req, 1'b1);
        inTxn = 0;
      end
      if (mem_req) begin
        if (!inTxn) begin
          inTxn = 1;
          latLeft = $urandom_range(1, 3);
          sAddr = mem_addr; sWe = mem_we; sBe = mem_be; sWdata = mem_wdata;
          txnFetch = !mem_addr[7];
          txnKilled = 0;
          if (prevDReq && (run < MAXS || !prevIfReq)) chk("rnd data has priority", txnFetch, 1'b0);
          else if (prevIfReq && !prevKill) chk("rnd fetch wins", txnFetch, 1'b1);
          if (txnFetch) run = 0;
          else run = prevIfReq ? run + 1 : 0;
          chk("rnd streak bound", run <= MAXS, 1'b1);
          chk32("rnd mem_addr", mem_addr, txnFetch ? fAddr : dAddr);
          chk("rnd mem_we", mem_we, txnFetch ? 1'b0 : dWe);
          chk32("rnd mem_be", 32'(mem_be), (txnFetch || !dWe) ? 32'hF : 32'(dBe));
          if (!txnFetch && dWe) chk32("rnd mem_wdata", mem_wdata, dWdata);
        end else begin
          chk32("rnd hold addr", mem_addr, sAddr);
          chk("rnd hold we", mem_we, sWe);
          chk32("rnd hold be", 32'(mem_be), 32'(sBe));
          chk32("rnd hold wdata", mem_wdata, sWdata);
        end
        if (txnFetch && if_kill) txnKilled = 1;
        latLeft--;
        if (latLeft == 0) begin
          mem_ack = 1;
          mem_rdata = envMem[mem_addr[7:2]];
          if (mem_we)
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) envMem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          ackValid = 1; ackFetch = txnFetch; ackKilled = txnKilled;
          inTxn = 0;
        end
      end
      #1;
      chk("rnd stall_mem", stall_mem, dPend && !expD);
      chk("rnd stall_if", stall_if, fPend && !expI && !if_kill);
      prevIfReq = fPend; prevKill = if_kill; prevDReq = dPend;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
